// File: rtl/if_fetch_align_pkg.sv
// Shared definitions for the fetch/align front-end: fetch FSM encodings,
// instruction length constants, default reset PC and a length helper.
package if_fetch_align_pkg;

    typedef enum logic [2:0] {
        F_IDLE = 3'd0,
        F_REQ  = 3'd1,
        F_WAIT = 3'd2,
        F_DROP = 3'd3,
        F_HALT = 3'd4
    } fetch_state_e;

    // Instruction lengths in bytes
    localparam logic [2:0] LEN_RVC  = 3'd2;
    localparam logic [2:0] LEN_FULL = 3'd4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

    // A halfword whose low two bits are 2'b11 starts a 32-bit instruction
    function automatic logic is_full_len(input logic [1:0] lo_bits);
        return (lo_bits == 2'b11);
    endfunction

endpackage

// File: rtl/if_fetch_align_word_fifo.sv
// Two-entry word FIFO for fetched words. Entry layout: bit 32 = fault,
// bits 31:0 = data. Entry 0 is always the head; a pop shifts entry 1 down.
// Clear has priority over push and pop.
module if_word_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [32:0] i_push_data,
    input  logic        i_pop,
    input  logic        i_clear,
    output logic [1:0]  o_count,
    output logic [32:0] o_head,
    output logic [15:0] o_second_lo,
    output logic        o_second_fault
);

    logic [32:0] r_entry0;
    logic [32:0] r_entry1;
    logic [1:0]  r_count;

    logic [32:0] w_entry0_nxt;
    logic [32:0] w_entry1_nxt;
    logic [1:0]  w_count_nxt;
    logic        w_pop;
    logic        w_push;

    // Next-state computation for entries and count, gating illegal push/pop
    always_comb begin
        w_pop        = i_pop && (r_count != 2'd0);
        w_push       = i_push && ((r_count != 2'd2) || w_pop);
        w_entry0_nxt = r_entry0;
        w_entry1_nxt = r_entry1;
        w_count_nxt  = r_count;
        if (i_clear) begin
            w_count_nxt = 2'd0;
        end else if (w_push && w_pop) begin
            if (r_count == 2'd2) begin
                w_entry0_nxt = r_entry1;
                w_entry1_nxt = i_push_data;
            end else begin
                w_entry0_nxt = i_push_data;
            end
        end else if (w_pop) begin
            w_entry0_nxt = r_entry1;
            w_count_nxt  = r_count - 2'd1;
        end else if (w_push) begin
            if (r_count == 2'd0) begin
                w_entry0_nxt = i_push_data;
            end else begin
                w_entry1_nxt = i_push_data;
            end
            w_count_nxt = r_count + 2'd1;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // FIFO storage and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry0 <= 33'h0;
            r_entry1 <= 33'h0;
            r_count  <= 2'd0;
        end else begin
            r_entry0 <= w_entry0_nxt;
            r_entry1 <= w_entry1_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign o_count        = r_count;
    assign o_head         = r_entry0;
    assign o_second_lo    = r_entry1[15:0];
    assign o_second_fault = r_entry1[32];

endmodule

// File: rtl/if_fetch_align.sv
// Fetch front-end: owns the fetch PC, issues one word request at a time to
// the icache, buffers up to two words and realigns 16/32-bit instructions
// (including word-straddling ones) for delivery to the IFU.
module if_fetch_align
    import if_fetch_align_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_ready_i,
    input  logic        fetch_rvalid_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_fault_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_data_o,
    output logic        inst_fault_o
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [29:0]  r_fptr;
    logic         r_fetch_req;

    logic         w_fetch_req_nxt;
    logic         w_push;
    logic         w_pop;
    logic         w_consume;
    logic [1:0]   w_fifo_count;
    logic [32:0]  w_head;
    logic [15:0]  w_second_lo;
    logic         w_second_fault;

    logic         w_inst_valid;
    logic [31:0]  w_inst_data;
    logic         w_inst_fault;
    logic [2:0]   w_len;
    logic [31:0]  w_pc_nxt;

    if_word_fifo u_word_fifo (
        .clk            (clk),
        .rst            (rst),
        .i_push         (w_push),
        .i_push_data    ({fetch_fault_i, fetch_rdata_i}),
        .i_pop          (w_pop),
        .i_clear        (redirect_valid_i),
        .o_count        (w_fifo_count),
        .o_head         (w_head),
        .o_second_lo    (w_second_lo),
        .o_second_fault (w_second_fault)
    );

    // Fetch FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch FSM next-state logic; redirect overrides everything. A response
    // that lands in the redirect cycle retires the outstanding request, so
    // WAIT/DROP return to IDLE instead of waiting for a response that never comes.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid_i) begin
            case (r_state)
                F_WAIT, F_DROP: w_state_nxt = fetch_rvalid_i ? F_IDLE : F_DROP;
                F_REQ:          w_state_nxt = fetch_ready_i ? F_DROP : F_IDLE;
                default:        w_state_nxt = F_IDLE;
            endcase
        end else begin
            case (r_state)
                F_IDLE: w_state_nxt = (w_fifo_count != 2'd2) ? F_REQ : F_IDLE;
                F_REQ:  w_state_nxt = fetch_ready_i ? F_WAIT : F_REQ;
                F_WAIT: begin
                    if (fetch_rvalid_i) begin
                        w_state_nxt = fetch_fault_i ? F_HALT : F_IDLE;
                    end else begin
                        w_state_nxt = F_WAIT;
                    end
                end
                F_DROP: w_state_nxt = fetch_rvalid_i ? F_IDLE : F_DROP;
                F_HALT: w_state_nxt = F_HALT;
                default: w_state_nxt = F_IDLE;
            endcase
        end
    end

    // Fetch FSM outputs: next-cycle request flag and FIFO push strobe
    always_comb begin
        w_fetch_req_nxt = (w_state_nxt == F_REQ);
        w_push          = (r_state == F_WAIT) && fetch_rvalid_i && !redirect_valid_i;
    end

    // Registered icache request valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_req <= 1'b0;
        end else begin
            r_fetch_req <= w_fetch_req_nxt;
        end
    end

    // Instruction extraction from the buffered words. A faulting head word is
    // delivered at once and consumes the rest of that word, so the stream
    // drains instead of repeating the fault at every halfword.
    always_comb begin
        w_inst_valid = 1'b0;
        w_inst_data  = 32'h0;
        w_inst_fault = 1'b0;
        w_len        = LEN_RVC;
        if (w_fifo_count != 2'd0) begin
            if (w_head[32]) begin
                w_inst_valid = 1'b1;
                w_inst_fault = 1'b1;
                w_len        = r_pc[1] ? LEN_RVC : LEN_FULL;
            end else if (!r_pc[1]) begin
                w_inst_valid = 1'b1;
                if (is_full_len(w_head[1:0])) begin
                    w_inst_data = w_head[31:0];
                    w_len       = LEN_FULL;
                end else begin
                    w_inst_data = {16'h0000, w_head[15:0]};
                end
            end else if (!is_full_len(w_head[17:16])) begin
                w_inst_valid = 1'b1;
                w_inst_data  = {16'h0000, w_head[31:16]};
            end else if (w_fifo_count == 2'd2) begin
                w_inst_valid = 1'b1;
                w_len        = LEN_FULL;
                w_inst_fault = w_second_fault;
                w_inst_data  = w_second_fault ? 32'h0 : {w_second_lo, w_head[31:16]};
            end else begin
                w_inst_valid = 1'b0;
            end
        end else begin
            w_inst_valid = 1'b0;
        end
    end

    // Consume handshake and head pop when the PC leaves the head word
    always_comb begin
        w_consume = w_inst_valid && inst_ready_i;
        w_pc_nxt  = r_pc + {29'h0, w_len};
        w_pop     = w_consume && (w_pc_nxt[31:2] != r_pc[31:2]);
    end

    // Deliver PC and fetch pointer; redirect has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_fptr <= RESET_PC[31:2];
        end else if (redirect_valid_i) begin
            r_pc   <= redirect_pc_i & 32'hFFFF_FFFE;
            r_fptr <= redirect_pc_i[31:2];
        end else begin
            if (w_consume) begin
                r_pc <= w_pc_nxt;
            end
            if ((r_state == F_REQ) && fetch_ready_i) begin
                r_fptr <= r_fptr + 30'd1;
            end
        end
    end

    assign fetch_req_o  = r_fetch_req;
    assign fetch_addr_o = {r_fptr, 2'b00};
    assign inst_valid_o = w_inst_valid;
    assign inst_addr_o  = r_pc;
    assign inst_data_o  = w_inst_data;
    assign inst_fault_o = w_inst_fault;

endmodule

// File: tb/tb_if_fetch_align.sv
// Scoreboard bench for if_fetch_align: directed scenarios push expected
// deliveries into a queue, a monitor pops and compares on each handshake,
// and a small icache model serves words from a sparse memory image.
module tb_if_fetch_align;

    logic        clk;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_ready_i;
    logic        fetch_rvalid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_fault_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_data_o;
    logic        inst_fault_o;

    if_fetch_align dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .fetch_req_o      (fetch_req_o),
        .fetch_addr_o     (fetch_addr_o),
        .fetch_ready_i    (fetch_ready_i),
        .fetch_rvalid_i   (fetch_rvalid_i),
        .fetch_rdata_i    (fetch_rdata_i),
        .fetch_fault_i    (fetch_fault_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_addr_o      (inst_addr_o),
        .inst_data_o      (inst_data_o),
        .inst_fault_o     (inst_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_deliv = 0;

    // icache model state
    logic [31:0] mem [logic [31:0]];
    int          cyc = 0;
    int          lat = 1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          resp_cyc = 0;
    int          n_acc = 0;
    logic [31:0] last_acc_addr = 32'h0;
    logic [31:0] last_resp_addr = 32'h0;
    logic        fault_en = 1'b0;
    logic [31:0] fault_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void expect_inst(input logic [31:0] a, input logic [31:0] d, input logic f);
        exp_t e;
        e.addr  = a;
        e.data  = d;
        e.fault = f;
        exp_q.push_back(e);
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0000_0013;
    endfunction

    // icache responder: accepts a request each cycle it is offered, answers after lat cycles
    initial begin
        fetch_ready_i  = 1'b1;
        fetch_rvalid_i = 1'b0;
        fetch_rdata_i  = 32'h0;
        fetch_fault_i  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            fetch_rvalid_i = 1'b0;
            fetch_rdata_i  = 32'h0;
            fetch_fault_i  = 1'b0;
            if (pend && cyc == resp_cyc) begin
                pend           = 1'b0;
                fetch_rvalid_i = 1'b1;
                last_resp_addr = pend_addr;
                if (fault_en && pend_addr == fault_addr) begin
                    fetch_fault_i = 1'b1;
                    fetch_rdata_i = 32'hDEAD_BEEF;
                end else begin
                    fetch_rdata_i = rd(pend_addr);
                end
            end
            if (!rst && fetch_req_o && fetch_ready_i) begin
                if (pend) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL overlap: request %h while %h outstanding", fetch_addr_o, pend_addr);
                end
                pend          = 1'b1;
                pend_addr     = fetch_addr_o;
                resp_cyc      = cyc + lat;
                n_acc++;
                last_acc_addr = fetch_addr_o;
            end
        end
    end

    // Monitor: every handshake pops one expectation and compares it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid_o && inst_ready_i) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got addr %h data %h, expected none", inst_addr_o, inst_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliv_addr", inst_addr_o, e.addr);
                    chk("deliv_data", inst_data_o, e.data);
                    chk("deliv_fault", 32'(inst_fault_o), 32'(e.fault));
                end
            end
        end
    end

    // Let the IFU accept exactly n instructions, bounded
    task automatic take(input int n);
        int target;
        int waited;
        target = n_deliv + n;
        waited = 0;
        @(posedge clk);
        #1;
        inst_ready_i = 1'b1;
        while (n_deliv < target && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        inst_ready_i = 1'b0;
        chk("take_count", 32'(n_deliv), 32'(target));
    endtask

    task automatic redirect(input logic [31:0] pc);
        @(posedge clk);
        #1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = pc;
        @(posedge clk);
        #1;
        redirect_valid_i = 1'b0;
    endtask

    initial begin
        int old;
        int waited;
        rst              = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        inst_ready_i     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_fetch_req", 32'(fetch_req_o), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst_inst_fault", 32'(inst_fault_o), 32'h0);

        // T1: first request in the second cycle, addi then next word
        mem[32'h3000_0000] = 32'h0000_0013;
        mem[32'h3000_0004] = 32'h0010_0093;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t1_req_cycle1", 32'(fetch_req_o), 32'h0);
        @(negedge clk);
        chk("t1_req_cycle2", 32'(fetch_req_o), 32'h1);
        chk("t1_addr_cycle2", fetch_addr_o, 32'h3000_0000);
        expect_inst(32'h3000_0000, 32'h0000_0013, 1'b0);
        expect_inst(32'h3000_0004, 32'h0010_0093, 1'b0);
        take(2);

        // T2: two compressed instructions in one word, then the next word
        mem[32'h3000_0000] = 32'h4501_4501;
        mem[32'h3000_0004] = 32'h0000_0013;
        redirect(32'h3000_0000);
        expect_inst(32'h3000_0000, 32'h0000_4501, 1'b0);
        expect_inst(32'h3000_0002, 32'h0000_4501, 1'b0);
        expect_inst(32'h3000_0004, 32'h0000_0013, 1'b0);
        take(3);

        // T3: 32-bit instruction straddling a word boundary
        mem[32'h3000_0100] = 32'h0093_ABCD;
        mem[32'h3000_0104] = 32'h1234_0000;
        redirect(32'h3000_0102);
        waited = 0;
        @(negedge clk);
        while (!inst_valid_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("t3_valid_seen", 32'(inst_valid_o), 32'h1);
        chk("t3_after_second_word", last_resp_addr, 32'h3000_0104);
        expect_inst(32'h3000_0102, 32'h0000_0093, 1'b0);
        take(1);

        // T4: redirect while waiting; the stale response is dropped
        lat = 3;
        mem[32'h3000_0200] = 32'h0020_0113;
        mem[32'h3000_0300] = 32'h0030_0193;
        redirect(32'h3000_0200);
        waited = 0;
        @(negedge clk);
        while (last_acc_addr != 32'h3000_0200 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("t4_first_req", last_acc_addr, 32'h3000_0200);
        old = n_acc;
        redirect(32'h3000_0300);
        lat = 1;
        waited = 0;
        @(negedge clk);
        while (n_acc == old && waited < 50) begin
            chk("t4_no_stale_valid", 32'(inst_valid_o), 32'h0);
            @(negedge clk);
            waited++;
        end
        chk("t4_new_req_addr", last_acc_addr, 32'h3000_0300);
        expect_inst(32'h3000_0300, 32'h0030_0193, 1'b0);
        take(1);

        // T5: faulting fetch halts the stream until redirect
        mem[32'h3000_0000] = 32'h0000_0013;
        mem[32'h3000_0004] = 32'h0000_0013;
        fault_en   = 1'b1;
        fault_addr = 32'h3000_0008;
        redirect(32'h3000_0000);
        expect_inst(32'h3000_0000, 32'h0000_0013, 1'b0);
        expect_inst(32'h3000_0004, 32'h0000_0013, 1'b0);
        expect_inst(32'h3000_0008, 32'h0000_0000, 1'b1);
        take(3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_halt_no_req", 32'(fetch_req_o), 32'h0);
        end
        chk("t5_drained", 32'(inst_valid_o), 32'h0);
        fault_en = 1'b0;

        // T6: IFU stall with full FIFO, then resume
        mem[32'h3000_0400] = 32'h0000_0013;
        mem[32'h3000_0404] = 32'h4501_4501;
        redirect(32'h3000_0400);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_stall_no_req", 32'(fetch_req_o), 32'h0);
            chk("t6_stall_valid", 32'(inst_valid_o), 32'h1);
            chk("t6_stall_addr", inst_addr_o, 32'h3000_0400);
            chk("t6_stall_data", inst_data_o, 32'h0000_0013);
        end
        expect_inst(32'h3000_0400, 32'h0000_0013, 1'b0);
        expect_inst(32'h3000_0404, 32'h0000_4501, 1'b0);
        expect_inst(32'h3000_0406, 32'h0000_4501, 1'b0);
        expect_inst(32'h3000_0408, 32'h0000_0013, 1'b0);
        take(4);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_align.md
Name: if_fetch_align

Overview:
- Fetch front-end directly upstream of the IFU stage.
- Owns the fetch PC and issues word-aligned 32-bit requests to the icache, one outstanding at a time.
- Buffers up to two fetched words and realigns halfword-aligned RVC/32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Delivers one raw instruction per handshake, with address and fault flag, to the IFU (which performs RVC expansion).

Parameters:
- RESET_PC, 32'h3000_0000, fetch/deliver PC loaded on reset; bit 0 must be 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_valid_i  in  1  flush/redirect from EX/trap
- redirect_pc_i  in  32  new PC; bit 0 ignored
- fetch_req_o  out  1  icache request valid (registered)
- fetch_addr_o  out  32  request address; bits[1:0]=0
- fetch_ready_i  in  1  icache accepts request
- fetch_rvalid_i  in  1  response valid, one cycle
- fetch_rdata_i  in  32  response word
- fetch_fault_i  in  1  access/page fault for the response word
- inst_valid_o  out  1  instruction available to IFU
- inst_ready_i  in  1  IFU accepts (not stalled)
- inst_addr_o  out  32  instruction PC
- inst_data_o  out  32  raw instruction; RVC = {16'h0, half}
- inst_fault_o  out  1  instruction fetch faulted; data forced to 0

Behaviour:
- Registers:
  - pc_q (next PC to deliver)
  - fptr_q[31:2] (next word to fetch)
  - 2-entry word FIFO: data[31:0] and fault bit per entry; head = word containing pc_q
  - fetch FSM
- Reset values: pc_q=RESET_PC, fptr_q=RESET_PC[31:2], FIFO empty, FSM=F_IDLE, fetch_req_o=0, inst_valid_o=0, inst_fault_o=0.
- Fetch FSM:
  - F_IDLE: if FIFO count<2, go F_REQ.
  - F_REQ: fetch_req_o=1, fetch_addr_o={fptr_q,2'b00} held stable. On fetch_ready_i, go F_WAIT and increment fptr_q (30-bit wrap).
  - F_WAIT: on fetch_rvalid_i, push {rdata, fault} into FIFO. Go F_HALT if fault, else F_IDLE.
  - F_DROP: on fetch_rvalid_i, discard the response and go F_IDLE.
  - F_HALT: no requests until redirect.
- Redirect (highest priority, any state):
  - pc_q <= redirect_pc_i & ~1; fptr_q <= redirect_pc_i[31:2]; FIFO cleared; inst_valid_o drops next cycle.
  - FSM next state: F_WAIT goes F_DROP. F_REQ goes F_DROP if fetch_ready_i is high the same cycle, else F_IDLE (withdrawal allowed by icache). F_DROP stays F_DROP. All other states go F_IDLE.
  - A response arriving in the redirect cycle is discarded.
- Delivery (combinational from registers; w0 = head, w1 = second entry):
  - pc_q[1]=0, w0 present: inst = w0, length 4 if w0[1:0]==2'b11, else {16'h0, w0[15:0]}, length 2.
  - pc_q[1]=1, w0 present, w0[17:16]!=2'b11: inst = {16'h0, w0[31:16]}, length 2.
  - pc_q[1]=1, 32-bit instruction: requires w1; inst = {w1[15:0], w0[31:16]}; inst_fault_o = w0.fault | w1.fault.
  - If w0.fault: deliver immediately with fault=1 and data=0, without waiting for w1.
  - inst_valid_o=1 only when all required words are present and no redirect is pending.
- Consume on inst_valid_o & inst_ready_i:
  - pc_q += length.
  - Pop w0 when (pc_q[1] + length/2) crosses the word boundary, i.e. new pc_q[31:2] != old.
  - A straddling instruction pops exactly w0; w1 becomes head.
- Outputs are stable while inst_valid_o & !inst_ready_i.
- Push and pop in the same cycle are legal: count stays the same.
- Latency:
  - A response in cycle N produces inst_valid_o in cycle N+1 (FIFO registered).
  - First request after reset release: fetch_req_o=1 in the second cycle.
- A fault-halted stream stays halted (F_HALT, FIFO drained) until redirect.

Decomposition:
- Shared package / sysconfig.v:
  - FSM state encodings F_IDLE/F_REQ/F_WAIT/F_DROP/F_HALT (3-bit)
  - RVC length constants
  - default RESET_PC define
- Sub-module if_word_fifo: 2-entry, 33-bit wide (data+fault) FIFO.
  - Ports: push, pop, clear, count, head/second views.
  - Clear has priority over push.

Test Plan:
- Reset, icache ready always, 1-cycle latency, words 0x00000013 (addi) at 0x30000000 -> fetch_addr_o=0x30000000 in the second cycle; inst_valid_o, inst_addr_o=0x30000000, inst_data_o=0x00000013; next delivery at 0x30000004.
- Word 0x45014501 (two c.li) at 0x30000000 -> two deliveries: 0x30000000 and 0x30000002, each inst_data_o=0x00004501; a single FIFO pop after the second.
- Redirect to 0x30000102; word@0x30000100=0x0093xxxx (upper half 0x0093), word@0x30000104=0xxxxx0000 -> deliver addr 0x30000102, data 0x00000093, only after the second word arrives.
- Redirect asserted while F_WAIT; the stale response arrives 2 cycles later -> discarded; next request uses the new address; no inst_valid_o for the stale word.
- fetch_fault_i=1 on word 0x30000008 -> inst_fault_o=1, data 0, addr 0x30000008; fetch_req_o stays 0 until redirect_valid_i.
- inst_ready_i held low 5 cycles with FIFO full -> no new fetch_req_o; outputs stable; resumes correctly when ready returns.
